// File: rtl/if_stage_stall_ctrl_pkg.sv
// if_stage_stall_ctrl_pkg: shared constants and FSM encoding for the fetch stall controller.
package if_stage_stall_ctrl_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR_C = 32'h0000_0013;
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;
endpackage

// File: rtl/if_stage_stall_ctrl_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with write-enable and flush (flush injects a NOP, valid=0).
module if_id_reg
    import if_stage_stall_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_we,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr,
    output logic            o_valid
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_pc    <= '0;
            o_instr <= NOP_INSTR;
            o_valid <= 1'b0;
        end else if (i_flush) begin
            o_pc    <= i_pc;
            o_instr <= NOP_INSTR;
            o_valid <= 1'b0;
        end else if (i_we) begin
            o_pc    <= i_pc;
            o_instr <= i_instr;
            o_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/if_stage_stall_ctrl.sv
// if_stage_stall_ctrl: PC register and IF/ID register driven by hazard-unit stalls and EX redirects.
// Defining STALL_STATS_EN adds the saturating stall_cnt statistics port.
module if_stage_stall_ctrl
    import if_stage_stall_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR   = NOP_INSTR_C,
    parameter int              STALL_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCwrite,
    input  logic            IF_IDwrite,
    input  logic            control_sel,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] imem_instr,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [XLEN-1:0] IF_ID_instr,
    output logic            IF_ID_valid,
`ifdef STALL_STATS_EN
    output logic [15:0]     stall_cnt,
`endif
    output logic            stall_err
);
    localparam int CW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STALL_LIMIT);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [CW-1:0]   r_run;
    logic [CW-1:0]   w_run_nxt;
    logic            r_err;
    logic            w_stall_cyc;
    state_t          r_state;
    state_t          w_state_nxt;

    // FSM state and bubble indication are debug-only observations
    logic w_unused;
    assign w_unused = ^{control_sel, r_state};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = pc_src ? S_FLUSH : (!PCwrite ? S_STALL : S_RUN);
    end

    always_comb begin
        w_stall_cyc = !PCwrite && !pc_src;
        w_pc_nxt    = pc_src ? branch_target : (PCwrite ? r_pc + 32'd4 : r_pc);
        w_run_nxt   = !w_stall_cyc ? '0 : (r_run == LIM ? r_run : r_run + 1'b1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_run <= '0;
            r_err <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_run <= w_run_nxt;
            r_err <= r_err | (w_run_nxt == LIM);
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .i_we    (IF_IDwrite),
        .i_flush (pc_src),
        .i_pc    (r_pc),
        .i_instr (imem_instr),
        .o_pc    (IF_ID_pc),
        .o_instr (IF_ID_instr),
        .o_valid (IF_ID_valid)
    );

`ifdef STALL_STATS_EN
    logic [15:0] r_stall_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                    r_stall_cnt <= '0;
        else if (w_stall_cyc && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
    assign stall_cnt = r_stall_cnt;
`endif

    assign imem_addr = r_pc;
    assign stall_err = r_err;
endmodule
